// File: rtl/ram_arb_pkg.sv
// Purpose : shared types and constants for the data-RAM port arbiter.
// Latency : n/a (types only).
// Backpr. : n/a.
// Contents: slot-state enum, owner encoding, default bus widths,
//           starvation-counter width, owner-to-slot helper.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int WAIT_CNT_W = 4;

  // What the RAM is doing in the current cycle.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_SLOT  = 2'd1,
    HOST_SLOT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  function automatic state_t slot_of(input owner_t own);
    return (own == OWN_HOST) ? HOST_SLOT : CPU_SLOT;
  endfunction

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Purpose : counts consecutive cycles the host loses contention; raises
//           force_host once the count reaches HOST_MAX_WAIT.
// Latency : force_host is a registered-count compare, valid every cycle.
// Backpr. : none; tracks host_req/host_gnt only.
// Ports   : clk, reset (async, active-high), host_req, host_gnt in;
//           force_host out.
module ram_arb_starve_ctr
  import ram_arb_pkg::*;
#(
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic host_req,
  input  logic host_gnt,
  output logic force_host
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT = WAIT_CNT_W'(HOST_MAX_WAIT);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  // Any host transfer or a withdrawn request restarts the wait window;
  // otherwise count losses, holding at the limit until the host wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!host_req || host_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_WAIT) begin
      wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
    end
  end

  assign force_host = (wait_cnt == MAX_WAIT);

endmodule

// File: rtl/ram_port_arbiter.sv
// Purpose : shares the single-port data RAM between the CPU and host ports,
//           CPU priority with a bounded wait for the host.
// Latency : gnt combinational; RAM slot 1 cycle after gnt; rvalid 2 cycles
//           after gnt.
// Backpr. : requester holds its bundle until gnt; 1 access/cycle total.
// Ports   : cpu_* / host_* request bundles and gnt/rvalid/rdata responses;
//           ram_en/ram_addr/ram_data/ram_q to the RAM instance.
// Option  : RAM_PORT_ARBITER_STATS_EN adds conflict_cnt[7:0] (saturating
//           count of cycles with both requests high).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
`ifdef RAM_PORT_ARBITER_STATS_EN
  ,
  output logic [7:0]        conflict_cnt
`endif
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              force_host;
  logic              cpu_rd_slot, host_rd_slot;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

  ram_arb_starve_ctr #(
    .HOST_MAX_WAIT(HOST_MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .host_req  (host_req),
    .host_gnt  (host_gnt),
    .force_host(force_host)
  );

  // Grants: CPU wins contention unless the host has waited its limit.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      if (cpu_req && host_req) begin
        if (force_host) host_gnt = 1'b1;
        else            cpu_gnt  = 1'b1;
      end else begin
        cpu_gnt  = cpu_req;
        host_gnt = host_req;
      end
    end
  end

  // State register plus latch of the committed access. The latch is only
  // loaded on a transfer, so ram_addr/ram_data hold while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cpu_gnt) begin
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
        lat_we    <= cpu_we;
      end else if (host_gnt) begin
        lat_addr  <= host_addr;
        lat_wdata <= host_wdata;
        lat_we    <= host_we;
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (cpu_gnt)       state_nxt = slot_of(OWN_CPU);
    else if (host_gnt) state_nxt = slot_of(OWN_HOST);
  end

  always_comb begin
    ram_en       = 1'b0;
    cpu_rd_slot  = 1'b0;
    host_rd_slot = 1'b0;
    case (state)
      CPU_SLOT: begin
        ram_en      = lat_we;
        cpu_rd_slot = !lat_we;
      end
      HOST_SLOT: begin
        ram_en       = lat_we;
        host_rd_slot = !lat_we;
      end
      default: ;
    endcase
  end

  assign ram_addr = lat_addr;
  assign ram_data = lat_wdata;

  // ram_q is valid the cycle after the read slot; pass it straight through
  // while rvalid is high and keep a copy so rdata holds afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid   <= 1'b0;
      host_rvalid  <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      cpu_rvalid  <= cpu_rd_slot;
      host_rvalid <= host_rd_slot;
      if (cpu_rvalid)  cpu_rdata_q  <= ram_q;
      if (host_rvalid) host_rdata_q <= ram_q;
    end
  end

  assign cpu_rdata  = cpu_rvalid  ? ram_q : cpu_rdata_q;
  assign host_rdata = host_rvalid ? ram_q : host_rdata_q;

`ifdef RAM_PORT_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (cpu_req && host_req && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural write-first
// single-port 128x8 RAM attached to the ram_* pins.
module tb_ram_port_arbiter;

  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, host_req, host_we;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [DW-1:0] cpu_wdata, host_wdata;
  logic          cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
  logic [DW-1:0] cpu_rdata, host_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
`ifdef RAM_PORT_ARBITER_STATS_EN
  logic [7:0]    conflict_cnt;
`endif

  int n_checks;
  int n_fail;

  logic [DW-1:0] mem [128];
  logic [DW-1:0] b2b [6];
  logic [9:0]    exp_host;

  always #5 clk = ~clk;

  // Write-first RAM: q is available the cycle after the address.
  always @(posedge clk) begin
    if (ram_en) begin
      mem[ram_addr] <= ram_data;
      ram_q         <= ram_data;
    end else begin
      ram_q <= mem[ram_addr];
    end
  end

  ram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .HOST_MAX_WAIT(MAXW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_q      (ram_q)
`ifdef RAM_PORT_ARBITER_STATS_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic idle_all();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_host(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33;
    b2b[3] = 8'h44; b2b[4] = 8'h55; b2b[5] = 8'h66;

    // ---- reset state: grants suppressed even with both requests high
    reset = 1'b1;
    idle_all();
    cpu_req  = 1'b1;
    host_req = 1'b1;
    repeat (2) tick();
    #1;
    check("rst_cpu_gnt",     32'(cpu_gnt),     32'h0);
    check("rst_host_gnt",    32'(host_gnt),    32'h0);
    check("rst_ram_en",      32'(ram_en),      32'h0);
    check("rst_ram_addr",    32'(ram_addr),    32'h0);
    check("rst_ram_data",    32'(ram_data),    32'h0);
    check("rst_cpu_rvalid",  32'(cpu_rvalid),  32'h0);
    check("rst_host_rvalid", 32'(host_rvalid), 32'h0);
    check("rst_cpu_rdata",   32'(cpu_rdata),   32'h0);
    check("rst_host_rdata",  32'(host_rdata),  32'h0);
    idle_all();
    reset = 1'b0;
    tick();

    // ---- host preloads 0x10=0xA5, CPU reads it back
    set_host(1'b1, 1'b1, 7'h10, 8'hA5);
    #1 check("t1_host_wr_gnt", 32'(host_gnt), 32'h1);
    check("t1_cpu_gnt_idle", 32'(cpu_gnt), 32'h0);
    tick();
    check("t1_wr_ram_en",   32'(ram_en),   32'h1);
    check("t1_wr_ram_addr", 32'(ram_addr), 32'h10);
    check("t1_wr_ram_data", 32'(ram_data), 32'hA5);
    set_host(1'b0, 1'b0, '0, '0);
    set_cpu(1'b1, 1'b0, 7'h10, 8'h00);
    #1 check("t1_cpu_rd_gnt", 32'(cpu_gnt), 32'h1);
    tick();
    set_cpu(1'b0, 1'b0, '0, '0);
    check("t1_rd_ram_en",     32'(ram_en),     32'h0);
    check("t1_rd_ram_addr",   32'(ram_addr),   32'h10);
    check("t1_rvalid_early",  32'(cpu_rvalid), 32'h0);
    tick();
    check("t1_cpu_rvalid",    32'(cpu_rvalid),  32'h1);
    check("t1_cpu_rdata",     32'(cpu_rdata),   32'hA5);
    check("t1_host_rvalid",   32'(host_rvalid), 32'h0);
    tick();
    check("t1_rvalid_pulse",  32'(cpu_rvalid), 32'h0);
    check("t1_rdata_hold",    32'(cpu_rdata),  32'hA5);
    check("t1_idle_ram_en",   32'(ram_en),     32'h0);
    check("t1_idle_addr_hold",32'(ram_addr),   32'h10);

    // ---- host writes 0x3C to 0x7F, CPU reads 0x7F in the next slot
    set_host(1'b1, 1'b1, 7'h7F, 8'h3C);
    #1 check("t2_host_gnt", 32'(host_gnt), 32'h1);
    tick();
    check("t2_ram_en_wr",   32'(ram_en),   32'h1);
    check("t2_ram_addr_7f", 32'(ram_addr), 32'h7F);
    check("t2_ram_data",    32'(ram_data), 32'h3C);
    set_host(1'b0, 1'b0, '0, '0);
    set_cpu(1'b1, 1'b0, 7'h7F, 8'h00);
    #1 check("t2_cpu_gnt", 32'(cpu_gnt), 32'h1);
    tick();
    set_cpu(1'b0, 1'b0, '0, '0);
    check("t2_ram_en_one_cycle", 32'(ram_en),   32'h0);
    check("t2_rd_addr_7f",       32'(ram_addr), 32'h7F);
    tick();
    check("t2_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    check("t2_cpu_rdata",  32'(cpu_rdata),  32'h3C);
    // address 0x00 through the host read path
    set_host(1'b1, 1'b1, 7'h00, 8'h5A);
    #1 check("t2_h0_wr_gnt", 32'(host_gnt), 32'h1);
    tick();
    check("t2_h0_ram_addr", 32'(ram_addr), 32'h00);
    check("t2_h0_ram_en",   32'(ram_en),   32'h1);
    set_host(1'b1, 1'b0, 7'h00, 8'h00);
    #1 check("t2_h0_rd_gnt", 32'(host_gnt), 32'h1);
    tick();
    set_host(1'b0, 1'b0, '0, '0);
    check("t2_h0_rd_ram_en", 32'(ram_en), 32'h0);
    tick();
    check("t2_host_rvalid", 32'(host_rvalid), 32'h1);
    check("t2_host_rdata",  32'(host_rdata),  32'h5A);
    check("t2_cpu_no_rvld", 32'(cpu_rvalid),  32'h0);
    tick();

    // ---- contention: CPU x4, host x1, repeating
    set_cpu(1'b1, 1'b0, 7'h01, 8'h00);
    set_host(1'b1, 1'b0, 7'h02, 8'h00);
    exp_host = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("cont_cpu_gnt[%0d]", i),  32'(cpu_gnt),  32'(!exp_host[i]));
      check($sformatf("cont_host_gnt[%0d]", i), 32'(host_gnt), 32'(exp_host[i]));
      tick();
    end
    // host withdraws before winning: its wait window restarts
    for (int i = 0; i < 2; i++) begin
      #1 check($sformatf("drop_pre_cpu[%0d]", i), 32'(cpu_gnt), 32'h1);
      tick();
    end
    host_req = 1'b0;
    #1 check("drop_cpu_gnt",  32'(cpu_gnt),  32'h1);
    check("drop_host_gnt", 32'(host_gnt), 32'h0);
    tick();
    host_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("drop_post_host[%0d]", i), 32'(host_gnt), 32'(i == 4));
      tick();
    end
    idle_all();
    repeat (2) tick();

    // ---- back-to-back: preload 0..5, then 6 consecutive CPU reads
    for (int i = 0; i < 6; i++) begin
      set_host(1'b1, 1'b1, 7'(i), b2b[i]);
      #1 check($sformatf("b2b_wr_gnt[%0d]", i), 32'(host_gnt), 32'h1);
      tick();
    end
    set_host(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 8; k++) begin
      if (k < 6) set_cpu(1'b1, 1'b0, 7'(k), 8'h00);
      else       set_cpu(1'b0, 1'b0, '0, '0);
      #1;
      if (k < 6) check($sformatf("b2b_gnt[%0d]", k), 32'(cpu_gnt), 32'h1);
      check($sformatf("b2b_rvalid[%0d]", k), 32'(cpu_rvalid), 32'(k >= 2));
      if (k >= 2) check($sformatf("b2b_rdata[%0d]", k - 2), 32'(cpu_rdata), 32'(b2b[k-2]));
      tick();
    end
    check("b2b_rvalid_end", 32'(cpu_rvalid), 32'h0);

    // ---- reset during a HOST_SLOT read of 0x7F
    set_host(1'b1, 1'b0, 7'h7F, 8'h00);
    #1 check("rms_host_gnt", 32'(host_gnt), 32'h1);
    tick();
    set_host(1'b0, 1'b0, '0, '0);
    #2 reset = 1'b1;
    #1;
    check("rms_ram_en",      32'(ram_en),      32'h0);
    check("rms_ram_addr",    32'(ram_addr),    32'h0);
    check("rms_ram_data",    32'(ram_data),    32'h0);
    check("rms_host_rvalid", 32'(host_rvalid), 32'h0);
    check("rms_host_rdata",  32'(host_rdata),  32'h0);
    check("rms_cpu_rdata",   32'(cpu_rdata),   32'h0);
    tick();
    check("rms_no_rvalid",   32'(host_rvalid), 32'h0);
    reset = 1'b0;
    set_cpu(1'b1, 1'b0, 7'h7F, 8'h00);
    #1 check("rms_after_gnt", 32'(cpu_gnt), 32'h1);
    tick();
    set_cpu(1'b0, 1'b0, '0, '0);
    check("rms_after_addr", 32'(ram_addr), 32'h7F);
    tick();
    check("rms_after_rvalid",  32'(cpu_rvalid),  32'h1);
    check("rms_after_rdata",   32'(cpu_rdata),   32'h3C);
    check("rms_after_hrvalid", 32'(host_rvalid), 32'h0);
    tick();

`ifdef RAM_PORT_ARBITER_STATS_EN
    // ---- conflict counter: counts, saturates, clears on reset
    check("st_start", 32'(conflict_cnt), 32'h0);
    set_cpu(1'b1, 1'b0, 7'h01, 8'h00);
    set_host(1'b1, 1'b0, 7'h02, 8'h00);
    repeat (10) tick();
    check("st_count10", 32'(conflict_cnt), 32'd10);
    repeat (290) tick();
    check("st_saturate", 32'(conflict_cnt), 32'hFF);
    reset = 1'b1;
    #1 check("st_reset", 32'(conflict_cnt), 32'h0);
    idle_all();
    tick();
    reset = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 128x8 data RAM between two requesters: the CPU core (execute-stage register accesses) and a host/debug port (program loader, memory inspection).
- Fixed CPU priority, with a bounded-wait guarantee for the host.
- Registers each committed access for one RAM slot cycle, then returns read data with a valid strobe.
- Sits between the CPU and the RAM instance; the RAM's data/addr/en/q pins connect only to this block.

Parameters:
- ADDR_W, 7, RAM address width (128 words).
- DATA_W, 8, RAM data width.
- HOST_MAX_WAIT, 4, maximum consecutive cycles the host loses contention before it is forced to win; range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request (level).
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  transfer accepted this cycle (combinational).
- cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse).
- cpu_rdata  out  DATA_W  CPU read data.
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request bundle, same meaning as the CPU bundle.
- host_gnt, host_rvalid, host_rdata  out  1/1/DATA_W  host responses, same meaning as the CPU responses.
- ram_en  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_q  in  DATA_W  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Clocking and reset: one clock (clk), rising edge; reset is asynchronous and active-high.
- Handshake: a transfer commits at the rising edge where req=1 and gnt=1.
  - The requester holds req/we/addr/wdata stable until gnt.
  - It may present the next request immediately.
  - Throughput is 1 access/cycle total.
- Grant logic (combinational; both gnt forced 0 while reset=1):
  - Only cpu_req: cpu_gnt=1.
  - Only host_req: host_gnt=1.
  - Both requesting: cpu_gnt=1, unless wait_cnt==HOST_MAX_WAIT, in which case host_gnt=1.
  - Never both grants at once.
- Starvation counter wait_cnt (4 bits):
  - Increments when host_req=1 and host_gnt=0.
  - Clears on a host transfer or when host_req=0.
  - Saturates at HOST_MAX_WAIT.
- FSM (state = what the RAM does this cycle):
  - IDLE: ram_en=0.
  - CPU_SLOT / HOST_SLOT: ram_addr/ram_data/ram_en come from the latched access of that owner; ram_en=we.
  - Every edge: a committed transfer moves to the owner's SLOT and latches addr/wdata/we; no transfer moves to IDLE.
  - SLOT to SLOT back-to-back is legal.
- Read return: a read in SLOT at cycle N gives rvalid=1 in cycle N+1, with rdata=ram_q, on that owner's port only.
  - Latency is 2 cycles from gnt to rvalid.
  - Writes produce no rvalid.
- Idle outputs: ram_addr/ram_data hold their last latched value; rdata holds its last value.
- Boundaries:
  - Address 0x7F and 0x00 pass through unchanged; no wrap logic.
  - Write followed by read of the same address in the next slot returns the new data (RAM write-first at the edge).
  - A requester dropping req without gnt has no effect.
- Reset (any time, including mid-slot):
  - State goes to IDLE; the pending slot and pending rvalid are discarded.
  - ram_en=0; ram_addr=0; ram_data=0; wait_cnt=0.
  - cpu_rvalid=host_rvalid=0; cpu_rdata=host_rdata=0.

Optional Feature:
- Macro: RAM_PORT_ARBITER_STATS_EN.
- Defined: adds output conflict_cnt [7:0], which increments on every cycle with cpu_req=1 and host_req=1.
  - Saturates at 0xFF.
  - Cleared by reset.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package ram_arb_pkg holds:
  - state enum {IDLE, CPU_SLOT, HOST_SLOT};
  - owner encoding OWN_CPU=0, OWN_HOST=1;
  - ADDR_W/DATA_W defaults;
  - the counter width constant.
- One natural sub-module, ram_arb_starve_ctr: wait_cnt counter plus force_host output; parameter HOST_MAX_WAIT.

Test Plan:
- CPU read: preload RAM[0x10]=0xA5; cpu_req read 0x10 -> cpu_gnt same cycle, ram_addr=0x10 next cycle, cpu_rvalid=1 with cpu_rdata=0xA5 two cycles after gnt; host_rvalid stays 0.
- Host write then CPU read: host writes 0x3C to 0x7F, CPU reads 0x7F in the next cycle -> ram_en=1 for exactly one cycle, cpu_rdata=0x3C; addresses 0x00 and 0x7F both reach the RAM.
- Contention with HOST_MAX_WAIT=4: both requesters held high -> CPU granted 4 cycles, host granted in the 5th, then CPU 4 more; grant pattern repeats and never overlaps.
- Back-to-back: CPU issues 6 consecutive reads of 0x00..0x05 -> 6 consecutive gnt cycles, 6 consecutive rvalid pulses carrying the correct data in order.
- Reset mid-slot: assert reset during a HOST_SLOT read -> ram_en=0, host_rvalid never pulses, all outputs at reset values; the next request after release completes normally.
- With RAM_PORT_ARBITER_STATS_EN: 300 contention cycles -> conflict_cnt saturates at 0xFF; reset returns it to 0.
